// File: rtl/cs_seq_pkg.sv
// cs_seq_pkg: shared definitions for the control-store micro-sequencer.
//   - default control-word and micro-op count widths
//   - position of the micro-op count field inside the control word
//   - sequencer state encoding
package cs_seq_pkg;

   localparam int unsigned CW_W_DEF   = 228;
   localparam int unsigned UCNT_W_DEF = 3;

   // The count field occupies the top UCNT_W bits of the control word.
   localparam int unsigned CNT_MSB_DEF = CW_W_DEF - 1;

   function automatic int unsigned cnt_msb(input int unsigned cw_w);
      return cw_w - 1;
   endfunction

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StFault
   } cs_state_e;

endpackage

// File: rtl/cs_sequencer.sv
// cs_sequencer: decode-stage micro-sequencer in front of the external control-store lookup.
// Accepts one instruction's opcode bytes per handshake, drives them to the lookup, latches the
// returned control word and issues it as 1..7 micro-op steps. A zero count field raises a
// one-cycle undefined-opcode fault instead of issuing.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   flush                    abort current instruction (below rst, above everything else)
//   in_valid/in_ready        opcode byte handshake, bytes on in_b1/in_b2/in_b3
//   cs_b1/cs_b2/cs_b3        bytes to the control-store lookup
//   cs_word                  lookup result, same cycle as cs_b*
//   out_valid/out_ready      micro-op handshake
//   out_cw/out_step/out_last latched control word, step index, final-step flag
//   ud_fault                 one-cycle undefined-opcode pulse
//   busy                     sequencer not idle
//
// Build option: define CS_SEQ_B2B_EN to accept the next instruction in the same cycle as the
// final-step handshake (cnt cycles per instruction instead of cnt+1).
module cs_sequencer
   import cs_seq_pkg::*;
#(
   parameter int unsigned CW_W   = CW_W_DEF,
   parameter int unsigned UCNT_W = UCNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [7:0]        in_b1,
   input  logic [7:0]        in_b2,
   input  logic [7:0]        in_b3,
   output logic [7:0]        cs_b1,
   output logic [7:0]        cs_b2,
   output logic [7:0]        cs_b3,
   input  logic [CW_W-1:0]   cs_word,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CW_W-1:0]   out_cw,
   output logic [UCNT_W-1:0] out_step,
   output logic              out_last,
   output logic              ud_fault,
   output logic              busy
);

`ifdef CS_SEQ_B2B_EN
   localparam bit B2bEn = 1'b1;
`else
   localparam bit B2bEn = 1'b0;
`endif

   localparam int unsigned CntMsb = cnt_msb(CW_W);

   cs_state_e         state_q, state_d;
   logic [7:0]        b1_q, b1_d, b2_q, b2_d, b3_q, b3_d;
   logic [CW_W-1:0]   cw_q, cw_d;
   logic [UCNT_W-1:0] cnt_q, cnt_d;
   logic [UCNT_W-1:0] step_q, step_d;

   logic              last;
   logic              b2b_take;
   logic              use_in;
   logic              accept;
   logic              fire;
   logic [UCNT_W-1:0] in_cnt;

   // Handshake and output decode.
   always_comb begin
      last      = (state_q == StIssue) && (step_q == cnt_q - UCNT_W'(1));
      // Final step completing with nobody flushing: the lookup port is free for a new opcode.
      b2b_take  = B2bEn && last && out_ready && !flush;
      use_in    = (state_q == StIdle) || b2b_take;
      // flush and rst suppress both handshakes so nothing completes in those cycles.
      in_ready  = !rst && !flush && use_in;
      out_valid = !rst && !flush && (state_q == StIssue);
      accept    = in_valid && in_ready;
      fire      = out_valid && out_ready;
      cs_b1     = use_in ? in_b1 : b1_q;
      cs_b2     = use_in ? in_b2 : b2_q;
      cs_b3     = use_in ? in_b3 : b3_q;
      in_cnt    = cs_word[CntMsb -: UCNT_W];
      out_cw    = cw_q;
      out_step  = step_q;
      out_last  = last;
      ud_fault  = (state_q == StFault);
      busy      = (state_q != StIdle);
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      b1_d    = b1_q;
      b2_d    = b2_q;
      b3_d    = b3_q;
      cw_d    = cw_q;
      cnt_d   = cnt_q;
      step_d  = step_q;

      if (flush) begin
         state_d = StIdle;
         step_d  = '0;
      end else begin
         unique case (state_q)
            StIdle: ;
            StIssue: begin
               if (fire) begin
                  if (last) begin
                     state_d = StIdle;
                     step_d  = '0;
                  end else begin
                     step_d = step_q + UCNT_W'(1);
                  end
               end
            end
            StFault: state_d = StIdle;
            default: state_d = StIdle;
         endcase

         // Acceptance overrides the return to idle when back-to-back issue is enabled.
         if (accept) begin
            b1_d    = in_b1;
            b2_d    = in_b2;
            b3_d    = in_b3;
            cw_d    = cs_word;
            cnt_d   = in_cnt;
            step_d  = '0;
            state_d = (in_cnt == '0) ? StFault : StIssue;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         b1_q    <= '0;
         b2_q    <= '0;
         b3_q    <= '0;
         cw_q    <= '0;
         cnt_q   <= '0;
         step_q  <= '0;
      end else begin
         state_q <= state_d;
         b1_q    <= b1_d;
         b2_q    <= b2_d;
         b3_q    <= b3_d;
         cw_q    <= cw_d;
         cnt_q   <= cnt_d;
         step_q  <= step_d;
      end
   end

endmodule

// File: tb/tb_cs_sequencer.sv
// tb_cs_sequencer: directed self-checking bench for cs_sequencer with a small control-store
// lookup model driven from cs_b*.
module tb_cs_sequencer;

   localparam int unsigned CW_W   = 228;
   localparam int unsigned UCNT_W = 3;

   logic              clk;
   logic              rst;
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [7:0]        in_b1, in_b2, in_b3;
   logic [7:0]        cs_b1, cs_b2, cs_b3;
   logic [CW_W-1:0]   cs_word;
   logic              out_valid;
   logic              out_ready;
   logic [CW_W-1:0]   out_cw;
   logic [UCNT_W-1:0] out_step;
   logic              out_last;
   logic              ud_fault;
   logic              busy;

   int passed = 0;
   int total  = 0;

   cs_sequencer #(
      .CW_W   (CW_W),
      .UCNT_W (UCNT_W)
   ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_b1     (in_b1),
      .in_b2     (in_b2),
      .in_b3     (in_b3),
      .cs_b1     (cs_b1),
      .cs_b2     (cs_b2),
      .cs_b3     (cs_b3),
      .cs_word   (cs_word),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_cw    (out_cw),
      .out_step  (out_step),
      .out_last  (out_last),
      .ud_fault  (ud_fault),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Control-store model: count field from a small opcode table, payload from the bytes.
   function automatic logic [CW_W-1:0] cs_fn(input logic [7:0] b1, input logic [7:0] b2,
                                             input logic [7:0] b3);
      logic [2:0] c;
      case (b1)
         8'h04:   c = 3'd1;
         8'h10:   c = 3'd2;
         8'h50:   c = 3'd3;
         8'h20:   c = 3'd4;
         8'h30:   c = 3'd5;
         8'h40:   c = 3'd7;
         default: c = 3'd0;
      endcase
      return {c, 8'h5A, 1'b1, {9{b1, b2, b3}}};
   endfunction

   always_comb cs_word = cs_fn(cs_b1, cs_b2, cs_b3);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_b1 = 8'h00; in_b2 = 8'h00; in_b3 = 8'h00;
      #1;
      total++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready_during_rst: got %b exp 0", in_ready); else passed++;
      tick(); tick();
      rst = 1'b0;
      #1;
      total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b exp 1", in_ready); else passed++;
      total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b exp 0", out_valid); else passed++;
      total++; if (out_cw !== '0) $display("FAIL reset_out_cw: got %h exp 0", out_cw); else passed++;
      total++; if (out_step !== 3'd0) $display("FAIL reset_out_step: got %0d exp 0", out_step); else passed++;
      total++; if (out_last !== 1'b0) $display("FAIL reset_out_last: got %b exp 0", out_last); else passed++;
      total++; if (ud_fault !== 1'b0) $display("FAIL reset_ud_fault: got %b exp 0", ud_fault); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b exp 0", busy); else passed++;
   endtask

   task automatic test_single_step();
      logic [CW_W-1:0] exp_cw;
      exp_cw = cs_fn(8'h04, 8'hC0, 8'h00);
      in_b1 = 8'h04; in_b2 = 8'hC0; in_b3 = 8'h00; in_valid = 1'b1; out_ready = 1'b1;
      #1;
      total++; if (in_ready !== 1'b1) $display("FAIL single_in_ready_idle: got %b exp 1", in_ready); else passed++;
      total++; if (cs_b1 !== 8'h04) $display("FAIL single_cs_b1_pass: got %h exp 04", cs_b1); else passed++;
      tick();
      in_valid = 1'b0; in_b1 = 8'hEE;
      #1;
      total++; if (out_valid !== 1'b1) $display("FAIL single_out_valid: got %b exp 1", out_valid); else passed++;
      total++; if (out_step !== 3'd0) $display("FAIL single_out_step: got %0d exp 0", out_step); else passed++;
      total++; if (out_last !== 1'b1) $display("FAIL single_out_last: got %b exp 1", out_last); else passed++;
      total++; if (out_cw !== exp_cw) $display("FAIL single_out_cw: got %h exp %h", out_cw, exp_cw); else passed++;
      total++; if (cs_b1 !== 8'h04) $display("FAIL single_cs_b1_latched: got %h exp 04", cs_b1); else passed++;
      tick();
      #1;
      total++; if (in_ready !== 1'b1) $display("FAIL single_in_ready_back: got %b exp 1", in_ready); else passed++;
      total++; if (out_valid !== 1'b0) $display("FAIL single_out_valid_done: got %b exp 0", out_valid); else passed++;
   endtask

   task automatic test_multi_step();
      logic [7:0] ops [2];
      int         cnts [2];
      ops[0] = 8'h50; cnts[0] = 3;
      ops[1] = 8'h40; cnts[1] = 7;
      for (int t = 0; t < 2; t++) begin
         in_b1 = ops[t]; in_b2 = 8'h00; in_b3 = 8'h00; in_valid = 1'b1; out_ready = 1'b1;
         tick();
         in_valid = 1'b0;
         for (int i = 0; i < cnts[t]; i++) begin
            #1;
            total++; if (out_valid !== 1'b1) $display("FAIL multi_out_valid op=%h step=%0d: got %b exp 1", ops[t], i, out_valid); else passed++;
            total++; if (out_step !== 3'(i)) $display("FAIL multi_out_step op=%h: got %0d exp %0d", ops[t], out_step, i); else passed++;
            total++; if (out_last !== (i == cnts[t] - 1)) $display("FAIL multi_out_last op=%h step=%0d: got %b", ops[t], i, out_last); else passed++;
            tick();
         end
         #1;
         total++; if (busy !== 1'b0) $display("FAIL multi_idle op=%h: busy got %b exp 0", ops[t], busy); else passed++;
      end
   endtask

   task automatic test_back_to_back();
      logic [CW_W-1:0] exp_cw;
      exp_cw = cs_fn(8'h10, 8'h11, 8'h00);
      in_b1 = 8'h04; in_b2 = 8'h00; in_b3 = 8'h00; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_b1 = 8'h10; in_b2 = 8'h11;
      #1;
`ifdef CS_SEQ_B2B_EN
      total++; if (in_ready !== 1'b1) $display("FAIL b2b_in_ready_last: got %b exp 1", in_ready); else passed++;
      total++; if (cs_b1 !== 8'h10) $display("FAIL b2b_cs_b1: got %h exp 10", cs_b1); else passed++;
      tick();
      in_valid = 1'b0;
      #1;
`else
      total++; if (in_ready !== 1'b0) $display("FAIL b2b_in_ready_last: got %b exp 0", in_ready); else passed++;
      tick();
      #1;
      total++; if (in_ready !== 1'b1) $display("FAIL b2b_in_ready_idle: got %b exp 1", in_ready); else passed++;
      tick();
      in_valid = 1'b0;
      #1;
`endif
      total++; if (out_valid !== 1'b1) $display("FAIL b2b_out_valid: got %b exp 1", out_valid); else passed++;
      total++; if (out_step !== 3'd0) $display("FAIL b2b_out_step: got %0d exp 0", out_step); else passed++;
      total++; if (out_cw !== exp_cw) $display("FAIL b2b_out_cw: got %h exp %h", out_cw, exp_cw); else passed++;
      tick(); tick();
   endtask

   task automatic test_backpressure();
      logic [CW_W-1:0] exp_cw;
      exp_cw = cs_fn(8'h10, 8'h22, 8'h00);
      in_b1 = 8'h10; in_b2 = 8'h22; in_b3 = 8'h00; in_valid = 1'b1; out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         total++; if (out_valid !== 1'b1) $display("FAIL bp_out_valid cyc=%0d: got %b exp 1", i, out_valid); else passed++;
         total++; if (out_step !== 3'd0) $display("FAIL bp_out_step cyc=%0d: got %0d exp 0", i, out_step); else passed++;
         total++; if (out_cw !== exp_cw) $display("FAIL bp_out_cw cyc=%0d: got %h exp %h", i, out_cw, exp_cw); else passed++;
         tick();
      end
      out_ready = 1'b1;
      #1;
      total++; if (out_step !== 3'd0) $display("FAIL bp_step_at_rise: got %0d exp 0", out_step); else passed++;
      tick();
      #1;
      total++; if (out_step !== 3'd1) $display("FAIL bp_step1: got %0d exp 1", out_step); else passed++;
      total++; if (out_last !== 1'b1) $display("FAIL bp_last: got %b exp 1", out_last); else passed++;
      tick();
   endtask

   task automatic test_fault();
      in_b1 = 8'hF1; in_b2 = 8'h00; in_b3 = 8'h00; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      #1;
      total++; if (ud_fault !== 1'b1) $display("FAIL fault_pulse: got %b exp 1", ud_fault); else passed++;
      total++; if (out_valid !== 1'b0) $display("FAIL fault_out_valid: got %b exp 0", out_valid); else passed++;
      total++; if (in_ready !== 1'b0) $display("FAIL fault_in_ready: got %b exp 0", in_ready); else passed++;
      tick();
      #1;
      total++; if (ud_fault !== 1'b0) $display("FAIL fault_pulse_end: got %b exp 0", ud_fault); else passed++;
      total++; if (in_ready !== 1'b1) $display("FAIL fault_in_ready_after: got %b exp 1", in_ready); else passed++;
      total++; if (out_valid !== 1'b0) $display("FAIL fault_out_valid_after: got %b exp 0", out_valid); else passed++;
   endtask

   task automatic test_flush();
      logic [CW_W-1:0] exp_cw;
      exp_cw = cs_fn(8'h04, 8'h33, 8'h00);
      in_b1 = 8'h20; in_b2 = 8'h00; in_b3 = 8'h00; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      #1;
      total++; if (out_step !== 3'd1) $display("FAIL flush_pre_step: got %0d exp 1", out_step); else passed++;
      flush = 1'b1;
      #1;
      total++; if (out_valid !== 1'b0) $display("FAIL flush_out_valid_forced: got %b exp 0", out_valid); else passed++;
      total++; if (in_ready !== 1'b0) $display("FAIL flush_in_ready_forced: got %b exp 0", in_ready); else passed++;
      tick();
      flush = 1'b0;
      #1;
      total++; if (busy !== 1'b0) $display("FAIL flush_idle: busy got %b exp 0", busy); else passed++;
      total++; if (out_valid !== 1'b0) $display("FAIL flush_out_valid_after: got %b exp 0", out_valid); else passed++;
      total++; if (in_ready !== 1'b1) $display("FAIL flush_in_ready_after: got %b exp 1", in_ready); else passed++;
      in_b1 = 8'h04; in_b2 = 8'h33; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      #1;
      total++; if (out_step !== 3'd0) $display("FAIL flush_new_step: got %0d exp 0", out_step); else passed++;
      total++; if (out_cw !== exp_cw) $display("FAIL flush_new_cw: got %h exp %h", out_cw, exp_cw); else passed++;
      // Flush coincides with the final-step handshake: the flush must win.
      in_b1 = 8'h10; in_valid = 1'b1; flush = 1'b1;
      #1;
      total++; if (out_valid !== 1'b0) $display("FAIL flush_last_out_valid: got %b exp 0", out_valid); else passed++;
      total++; if (in_ready !== 1'b0) $display("FAIL flush_last_in_ready: got %b exp 0", in_ready); else passed++;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      #1;
      total++; if (busy !== 1'b0) $display("FAIL flush_last_idle: busy got %b exp 0", busy); else passed++;
   endtask

   task automatic test_reset_mid();
      in_b1 = 8'h30; in_b2 = 8'h00; in_b3 = 8'h00; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      tick(); tick();
      #1;
      total++; if (out_step !== 3'd2) $display("FAIL rstmid_pre_step: got %0d exp 2", out_step); else passed++;
      rst = 1'b1;
      #1;
      total++; if (in_ready !== 1'b0) $display("FAIL rstmid_in_ready_during: got %b exp 0", in_ready); else passed++;
      tick();
      rst = 1'b0;
      #1;
      total++; if (out_valid !== 1'b0) $display("FAIL rstmid_out_valid: got %b exp 0", out_valid); else passed++;
      total++; if (out_cw !== '0) $display("FAIL rstmid_out_cw: got %h exp 0", out_cw); else passed++;
      total++; if (out_step !== 3'd0) $display("FAIL rstmid_out_step: got %0d exp 0", out_step); else passed++;
      total++; if (out_last !== 1'b0) $display("FAIL rstmid_out_last: got %b exp 0", out_last); else passed++;
      total++; if (ud_fault !== 1'b0) $display("FAIL rstmid_ud_fault: got %b exp 0", ud_fault); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b exp 0", busy); else passed++;
      total++; if (in_ready !== 1'b1) $display("FAIL rstmid_in_ready: got %b exp 1", in_ready); else passed++;
   endtask

   initial begin
      test_reset();
      test_single_step();
      test_multi_step();
      test_back_to_back();
      test_backpressure();
      test_fault();
      test_flush();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
